noc_credit_link_rx: RTL

//  Receive end of the credit-based rtr-to-rtr link (data/dest/is_tail/send forward, credit back).

---
 rtl/noc_link_pkg.sv | 6 +
 rtl/noc_flit_fifo.sv | 36 +++
 rtl/noc_credit_link_rx.sv | 78 +++++++
 3 files changed

// File: rtl/noc_link_pkg.sv
// noc_link_pkg: shared types and default widths for the credit-based router link.
package noc_link_pkg;
  localparam int DEF_FLIT_WIDTH = 64;
  localparam int DEF_DEST_WIDTH = 6;
  typedef enum logic {TRK_HEAD, TRK_BODY} trk_e;
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: first-word-fall-through FIFO with wrap-bit pointers and occupancy count.
module noc_flit_fifo #(
  parameter int W     = 71,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  // Storage is not reset; validity comes solely from the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;
  assign full_o  = count_o == (AW+1)'(DEPTH);
  assign empty_o = count_o == '0;
endmodule

// File: rtl/noc_credit_link_rx.sv
// noc_credit_link_rx: link receiver buffering flits, returning credits on pop and checking packet framing.
module noc_credit_link_rx
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH        = DEF_FLIT_WIDTH,
  parameter int DEST_WIDTH        = DEF_DEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                                 clk_noc,
  input  logic                                 rst_noc,
  input  logic [FLIT_WIDTH-1:0]                data_in,
  input  logic [DEST_WIDTH-1:0]                dest_in,
  input  logic                                 is_tail_in,
  input  logic                                 send_in,
  output logic                                 credit_out,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [FLIT_WIDTH-1:0]                out_data,
  output logic [DEST_WIDTH-1:0]                out_dest,
  output logic                                 out_is_tail,
  output logic [$clog2(FLIT_BUFFER_DEPTH):0]   occupancy,
  output logic [CNT_WIDTH-1:0]                 pkt_count,
  output logic                                 err_overflow,
  output logic                                 err_dest_mis,
  input  logic                                 err_clear
);
  localparam int W = FLIT_WIDTH + DEST_WIDTH + 1;
  logic                  full, empty, pop, push, ovf, mis;
  logic [W-1:0]          head;
  logic                  credit_q, err_ovf_q, err_ovf_d, err_mis_q, err_mis_d;
  logic [CNT_WIDTH-1:0]  pkt_q;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  trk_e                  trk_q, trk_d;
  noc_flit_fifo #(.W(W), .DEPTH(FLIT_BUFFER_DEPTH)) u_fifo (
    .clk(clk_noc), .rst(rst_noc), .push_i(push), .pop_i(pop),
    .din_i({is_tail_in, dest_in, data_in}), .dout_o(head),
    .full_o(full), .empty_o(empty), .count_o(occupancy)
  );
  assign out_valid = !empty;
  assign {out_is_tail, out_dest, out_data} = head;
  assign pop  = out_valid && out_ready;
  // A pop frees a slot at the same edge, so a full FIFO can still take the arriving flit.
  assign push = send_in && (!full || pop);
  assign ovf  = send_in && full && !pop;
  assign mis  = push && trk_q == TRK_BODY && dest_in != dest_q;
  always_comb begin
    trk_d     = trk_q;
    dest_d    = dest_q;
    if (push) begin
      dest_d = trk_q == TRK_HEAD ? dest_in : dest_q;
      trk_d  = is_tail_in ? TRK_HEAD : TRK_BODY;
    end
    err_ovf_d = ovf || (err_ovf_q && !err_clear);
    err_mis_d = mis || (err_mis_q && !err_clear);
  end
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      credit_q  <= 1'b0;
      pkt_q     <= '0;
      err_ovf_q <= 1'b0;
      err_mis_q <= 1'b0;
      trk_q     <= TRK_HEAD;
      dest_q    <= '0;
    end else begin
      credit_q  <= pop;
      pkt_q     <= pkt_q + CNT_WIDTH'(pop && out_is_tail);
      err_ovf_q <= err_ovf_d;
      err_mis_q <= err_mis_d;
      trk_q     <= trk_d;
      dest_q    <= dest_d;
    end
  end
  assign credit_out   = credit_q;
  assign pkt_count    = pkt_q;
  assign err_overflow = err_ovf_q;
  assign err_dest_mis = err_mis_q;
endmodule
